bram0_stream_loader: RTL and testbench
======================================

// Module: bram0_stream_loader
// PURPOSE
//  Upstream feeder for BRAM_accessor. Accepts an 8-bit valid/ready byte stream and packs 4 bytes per 32-bit word.
//  Writes each word into BRAM0 through port A while the accessor owns port B.
//  At end of frame, pulses start_run_o with run_count_o = last word address, then holds off until done_i.
// PARAMETERS
//  CNT_BIT        31   width of run_count_o; matches BRAM_accessor run_count_i
//  DWIDTH_1       32   BRAM0 word width; fixed at 4*IN_DATA_WIDTH
//  AWIDTH         8    BRAM0 address width
//  MEM_SIZE       256  BRAM0 depth in words; must be <= 2**AWIDTH
//  IN_DATA_WIDTH  8    byte (lane) width
// PORTS
//  clk          in   1              clock, rising edge
//  reset_n      in   1              asynchronous active-low reset
//  s_valid_i    in   1              input byte valid
//  s_ready_o    out  1              loader can accept a byte
//  s_data_i     in   IN_DATA_WIDTH  input byte
//  s_last_i     in   1              marks the final byte of a frame; qualified by valid&ready
//  done_i       in   1              BRAM_accessor done_o
//  start_run_o  out  1              one-cycle pulse to BRAM_accessor start_run_i
//  run_count_o  out  CNT_BIT        words written minus 1; held stable from pulse until next start
//  addr_b0_o    out  AWIDTH         BRAM0 write address
//  ce_b0_o      out  1              BRAM0 chip enable
//  we_b0_o      out  1              BRAM0 write enable
//  d_b0_o       out  DWIDTH_1       BRAM0 write data
//  busy_o       out  1              high whenever state != S_IDLE
//  ovf_o        out  1              sticky: frame exceeded MEM_SIZE words; cleared by next frame's first byte
// BEHAVIOUR
//  Reset values: all outputs 0 except s_ready_o = 1. State S_IDLE, word_ptr = 0, lane = 0, pack register = 0.
//  States: S_IDLE, S_FILL, S_KICK, S_WAIT.
//   S_IDLE -> S_FILL on the first accepted byte.
//   S_FILL -> S_KICK on the cycle after accepting the byte with s_last_i.
//   S_KICK -> S_WAIT after 1 cycle.
//   S_WAIT -> S_IDLE when done_i = 1.
//  s_ready_o = 1 in S_IDLE and S_FILL only. It is registered-clean, with no combinational path from s_valid_i.
//  Packing: the first byte of a word goes to [31:24], then [23:16], [15:8], [7:0].
//   Example: bytes 01,03,05,07 produce 32'h01030507.
//  Write timing: on accepting the 4th byte, or any byte with s_last_i, the next cycle drives:
//   ce_b0_o = we_b0_o = 1, addr_b0_o = word_ptr, d_b0_o = packed word.
//   Lanes not filled in a partial final word are 0.
//  Write timing, continued: the write strobe is 1 cycle wide. word_ptr increments and lane clears at the same edge.
//   Throughput is 1 byte per cycle with no bubbles.
//  ce/we/addr/d return to 0 whenever no write is in progress.
//  Latency: last byte accepted at edge N -> BRAM write in cycle N+1 -> start_run_o = 1 in cycle N+2 (S_KICK).
//  run_count_o = words_written - 1, zero-extended to CNT_BIT. It is loaded in the same cycle start_run_o rises.
//  done_i is ignored outside S_WAIT. A done_i already high on S_WAIT entry exits on that edge.
//  Overflow: once MEM_SIZE words have been written in a frame, further bytes are still accepted.
//   These bytes are dropped: no write occurs and word_ptr does not wrap. ovf_o sets to 1.
//   run_count_o is then MEM_SIZE-1.
//  New frame: word_ptr and ovf_o clear when the first byte of the next frame is accepted in S_IDLE.
//  Reset mid-operation: return immediately to reset values. A partially packed word is discarded with no write.
//   No start_run_o pulse is issued.
// TESTING
//  Frame of 1024 bytes (01,03,05,07 repeated) -> 256 writes of 32'h01030507 at addr 0..255.
//   Then one start_run_o pulse with run_count_o = 255.
//  Frame of 6 bytes AA..FF with last on FF -> writes: addr0 = AABBCCDD, addr1 = EEFF0000.
//   start_run_o 2 cycles after FF accepted; run_count_o = 1.
//  s_valid_i toggling every other cycle -> same BRAM contents as back-to-back input.
//   No write occurs without a completed word or last.
//  Frame of 1030 bytes -> 256 writes; ovf_o = 1; run_count_o = 255; s_ready_o stays 1 until last.
//   Next frame's first byte clears ovf_o.
//  In S_WAIT, s_valid_i held 1 -> s_ready_o = 0 until done_i is pulsed, then the next byte is accepted.
//   An early done_i pulse before S_WAIT has no effect.
//  reset_n low after 2 bytes of a word -> no write, no start_run_o.
//   After release, a fresh 4-byte frame writes to addr 0.

Source files
------------

// File: rtl/bram0_stream_loader_if.sv
// Byte-stream handshake bundle feeding bram0_stream_loader.
//   s_valid_i : producer has a byte on s_data_i
//   s_ready_o : loader can accept a byte this cycle (registered in the loader)
//   s_data_i  : byte payload
//   s_last_i  : final byte of a frame, qualified by valid & ready
// The master modport is the byte producer; the slave modport is the loader.
interface bram0_stream_loader_if #(
  parameter int IN_DATA_WIDTH = 8
);
  logic                     s_valid_i;
  logic                     s_ready_o;
  logic [IN_DATA_WIDTH-1:0] s_data_i;
  logic                     s_last_i;

  modport master (output s_valid_i, output s_data_i, output s_last_i, input s_ready_o);
  modport slave  (input s_valid_i, input s_data_i, input s_last_i, output s_ready_o);
endinterface

// File: rtl/bram0_stream_loader.sv
// Packs an incoming byte stream into 32-bit words and writes them into BRAM0
// through port A. At the end of a frame it pulses start_run_o towards the
// BRAM accessor, with run_count_o = last word address, and then waits for
// done_i before it accepts the next frame.
// Ports:
//   clk, reset_n              clock (rising edge), async active-low reset
//   s (slave)                 valid/ready byte stream with last marker
//   done_i                    accessor finished its run
//   start_run_o, run_count_o  run kick pulse and word count minus one
//   addr_b0_o, ce_b0_o,
//   we_b0_o, d_b0_o           BRAM0 port-A write strobe and payload
//   busy_o                    loader is not idle
//   ovf_o                     sticky: the frame held more words than BRAM0
module bram0_stream_loader #(
  parameter int CNT_BIT       = 31,
  parameter int DWIDTH_1      = 32,
  parameter int AWIDTH        = 8,
  parameter int MEM_SIZE      = 256,
  parameter int IN_DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  bram0_stream_loader_if.slave s,
  input  logic                done_i,
  output logic                start_run_o,
  output logic [CNT_BIT-1:0]  run_count_o,
  output logic [AWIDTH-1:0]   addr_b0_o,
  output logic                ce_b0_o,
  output logic                we_b0_o,
  output logic [DWIDTH_1-1:0] d_b0_o,
  output logic                busy_o,
  output logic                ovf_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_KICK = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  // The pointer is one bit wider than the address so that "memory full"
  // (MEM_SIZE words written) is representable without wrapping.
  localparam logic [AWIDTH:0] MEM_LIMIT = (AWIDTH + 1)'(MEM_SIZE);
  localparam int              IW        = IN_DATA_WIDTH;

  state_t              state_r;
  logic [AWIDTH:0]     word_ptr_r;
  logic [1:0]          lane_r;
  logic [DWIDTH_1-1:0] pack_r;
  logic                last_pend_r;

  logic                accept_s;
  logic [DWIDTH_1-1:0] word_s;
  logic [AWIDTH:0]     ptr_base_s;
  logic                room_s;
  logic                word_done_s;
  logic [AWIDTH:0]     ptr_m1_s;

  // Merge the incoming byte into its lane and decide whether a word completes.
  always_comb begin
    accept_s = s.s_valid_i & s.s_ready_o;
    word_s   = pack_r;
    case (lane_r)
      2'd0:    word_s[4*IW-1 -: IW] = s.s_data_i;
      2'd1:    word_s[3*IW-1 -: IW] = s.s_data_i;
      2'd2:    word_s[2*IW-1 -: IW] = s.s_data_i;
      2'd3:    word_s[1*IW-1 -: IW] = s.s_data_i;
      default: word_s = pack_r;
    endcase
    // The first byte of a frame starts from address 0 even though the
    // pointer register still holds the previous frame's count.
    if (state_r == S_IDLE) begin
      ptr_base_s = '0;
    end else begin
      ptr_base_s = word_ptr_r;
    end
    room_s      = (ptr_base_s < MEM_LIMIT);
    word_done_s = (lane_r == 2'd3) | s.s_last_i;
    ptr_m1_s    = word_ptr_r - {{AWIDTH{1'b0}}, 1'b1};
  end

  // Frame FSM with all outputs registered; write strobe and kick are one-cycle pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      word_ptr_r  <= '0;
      lane_r      <= 2'd0;
      pack_r      <= '0;
      last_pend_r <= 1'b0;
      s.s_ready_o <= 1'b1;
      start_run_o <= 1'b0;
      run_count_o <= '0;
      addr_b0_o   <= '0;
      ce_b0_o     <= 1'b0;
      we_b0_o     <= 1'b0;
      d_b0_o      <= '0;
      busy_o      <= 1'b0;
      ovf_o       <= 1'b0;
    end else begin
      ce_b0_o     <= 1'b0;
      we_b0_o     <= 1'b0;
      addr_b0_o   <= '0;
      d_b0_o      <= '0;
      start_run_o <= 1'b0;
      case (state_r)
        S_IDLE, S_FILL: begin
          if (last_pend_r) begin
            // The final word went out last cycle; now kick the accessor.
            state_r     <= S_KICK;
            last_pend_r <= 1'b0;
            start_run_o <= 1'b1;
            run_count_o <= {{(CNT_BIT - AWIDTH - 1){1'b0}}, ptr_m1_s};
          end else if (accept_s) begin
            state_r <= S_FILL;
            busy_o  <= 1'b1;
            if (!room_s) begin
              ovf_o <= 1'b1;
            end else if (state_r == S_IDLE) begin
              ovf_o <= 1'b0;
            end else begin
              ovf_o <= ovf_o;
            end
            if (word_done_s) begin
              lane_r <= 2'd0;
              pack_r <= '0;
              if (room_s) begin
                ce_b0_o    <= 1'b1;
                we_b0_o    <= 1'b1;
                addr_b0_o  <= ptr_base_s[AWIDTH-1:0];
                d_b0_o     <= word_s;
                word_ptr_r <= ptr_base_s + {{AWIDTH{1'b0}}, 1'b1};
              end else begin
                word_ptr_r <= ptr_base_s;
              end
            end else begin
              lane_r     <= lane_r + 2'd1;
              pack_r     <= word_s;
              word_ptr_r <= ptr_base_s;
            end
            if (s.s_last_i) begin
              last_pend_r <= 1'b1;
              s.s_ready_o <= 1'b0;
            end else begin
              last_pend_r <= 1'b0;
            end
          end else begin
            state_r <= state_r;
          end
        end
        S_KICK: begin
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (done_i) begin
            state_r     <= S_IDLE;
            s.s_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else begin
            state_r <= S_WAIT;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          s.s_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          last_pend_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram0_stream_loader.sv
// Self-checking bench for bram0_stream_loader. A small packing model pushes
// expected BRAM writes and run counts into queues as bytes are driven;
// monitors pop and compare when the DUT strobes a write or a kick.
module tb_bram0_stream_loader;

  logic        clk;
  logic        reset_n;
  logic        done_i;
  logic        start_run_o;
  logic [30:0] run_count_o;
  logic [7:0]  addr_b0_o;
  logic        ce_b0_o;
  logic        we_b0_o;
  logic [31:0] d_b0_o;
  logic        busy_o;
  logic        ovf_o;

  bram0_stream_loader_if sif ();

  bram0_stream_loader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s           (sif),
    .done_i      (done_i),
    .start_run_o (start_run_o),
    .run_count_o (run_count_o),
    .addr_b0_o   (addr_b0_o),
    .ce_b0_o     (ce_b0_o),
    .we_b0_o     (we_b0_o),
    .d_b0_o      (d_b0_o),
    .busy_o      (busy_o),
    .ovf_o       (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [39:0] wr_q[$];
  logic [30:0] run_q[$];
  int          wr_seen = 0;

  int          m_lane = 0;
  logic [31:0] m_word = '0;
  int          m_ptr  = 0;
  int          wait_max = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference packing: first byte lands in [31:24]; partial words zero-filled.
  task automatic model_byte(input logic [7:0] d, input bit l);
    m_word[(3 - m_lane) * 8 +: 8] = d;
    if (m_lane == 3 || l) begin
      if (m_ptr < 256) begin
        wr_q.push_back({m_ptr[7:0], m_word});
        m_ptr++;
      end
      m_word = '0;
      m_lane = 0;
    end else begin
      m_lane++;
    end
    if (l) begin
      run_q.push_back(31'(m_ptr - 1));
      m_ptr = 0;
    end
  endtask

  task automatic model_reset();
    m_lane = 0;
    m_word = '0;
    m_ptr  = 0;
  endtask

  // Drive one byte and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input bit l, input int gap);
    int waited;
    waited = 0;
    sif.s_valid_i = 1'b1;
    sif.s_data_i  = d;
    sif.s_last_i  = l;
    model_byte(d, l);
    @(negedge clk);
    while (!sif.s_ready_o && waited < 2000) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 2000) begin
      check("ready_timeout", 64'(waited), 64'd0);
    end
    if (waited > wait_max) wait_max = waited;
    @(posedge clk);
    #1;
    sif.s_valid_i = 1'b0;
    sif.s_last_i  = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Let the kick happen, then release the loader with a one-cycle done.
  task automatic finish_run();
    repeat (3) @(posedge clk);
    #1;
    check("wait_busy", 64'(busy_o), 64'd1);
    check("wait_ready", 64'(sif.s_ready_o), 64'd0);
    done_i = 1'b1;
    @(posedge clk);
    #1;
    done_i = 1'b0;
  endtask

  task automatic send_pattern_frame(input int nbytes);
    logic [7:0] pat [4];
    pat[0] = 8'h01; pat[1] = 8'h03; pat[2] = 8'h05; pat[3] = 8'h07;
    for (int i = 0; i < nbytes; i++) begin
      send_byte(pat[i % 4], (i == nbytes - 1), 0);
    end
  endtask

  // Write monitor: every strobe must match the next expected word.
  always @(negedge clk) begin
    if (reset_n && (we_b0_o || ce_b0_o)) begin
      wr_seen++;
      if (wr_q.size() == 0) begin
        check("unexpected_write", {24'd0, addr_b0_o, d_b0_o}, 64'd0);
      end else begin
        logic [39:0] e;
        e = wr_q.pop_front();
        check("wr_addr", 64'(addr_b0_o), 64'(e[39:32]));
        check("wr_data", 64'(d_b0_o), 64'(e[31:0]));
        check("wr_we", 64'(we_b0_o), 64'd1);
      end
    end
  end

  // Kick monitor: each start pulse consumes one expected run count.
  always @(negedge clk) begin
    if (reset_n && start_run_o) begin
      if (run_q.size() == 0) begin
        check("unexpected_start", 64'(run_count_o), 64'h7fffffff);
      end else begin
        check("run_count", 64'(run_count_o), 64'(run_q.pop_front()));
      end
    end
  end

  initial begin
    reset_n       = 1'b0;
    done_i        = 1'b0;
    sif.s_valid_i = 1'b0;
    sif.s_data_i  = 8'h00;
    sif.s_last_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(sif.s_ready_o), 64'd1);
    check("rst_outs", {busy_o, ovf_o, start_run_o, ce_b0_o, we_b0_o, 31'(run_count_o)}, 64'd0);
    check("rst_bus", {24'd0, addr_b0_o, d_b0_o}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-memory frame of repeating 01,03,05,07.
    wr_seen = 0;
    send_pattern_frame(1024);
    finish_run();
    check("full_writes", 64'(wr_seen), 64'd256);
    check("full_ovf", 64'(ovf_o), 64'd0);

    // Six-byte frame with a partial final word and exact kick latency.
    // An early done pulse right after the last byte must be ignored.
    wr_seen = 0;
    for (int i = 0; i < 5; i++) send_byte(8'hAA + 8'(i * 17), 1'b0, 0);
    send_byte(8'hFF, 1'b1, 0);
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    check("lat_wr", 64'(we_b0_o), 64'd1);
    check("lat_nostart", 64'(start_run_o), 64'd0);
    @(negedge clk);
    check("lat_start", 64'(start_run_o), 64'd1);
    check("lat_cnt", 64'(run_count_o), 64'd1);
    repeat (4) @(negedge clk);
    check("early_done_busy", 64'(busy_o), 64'd1);
    check("early_done_ready", 64'(sif.s_ready_o), 64'd0);
    check("run_count_hold", 64'(run_count_o), 64'd1);
    #1;
    // Valid held high in S_WAIT: the byte waits until done.
    sif.s_valid_i = 1'b1;
    sif.s_data_i  = 8'h11;
    @(negedge clk);
    check("wait_hold_ready", 64'(sif.s_ready_o), 64'd0);
    done_i = 1'b1;
    @(posedge clk);
    #1;
    done_i = 1'b0;
    check("six_writes", 64'(wr_seen), 64'd2);
    // Toggled-valid frame starts with that pending byte.
    wr_seen = 0;
    send_byte(8'h11, 1'b0, 1);
    for (int i = 1; i < 7; i++) send_byte(8'h11 * 8'(i + 1), 1'b0, 1);
    send_byte(8'h88, 1'b1, 1);
    finish_run();
    check("toggle_writes", 64'(wr_seen), 64'd2);

    // Overflow frame: 1030 bytes, ready never drops before the last byte.
    wr_seen  = 0;
    wait_max = 0;
    send_pattern_frame(1030);
    check("ovf_noready_stall", 64'(wait_max), 64'd0);
    check("ovf_set", 64'(ovf_o), 64'd1);
    finish_run();
    check("ovf_writes", 64'(wr_seen), 64'd256);
    check("ovf_sticky", 64'(ovf_o), 64'd1);
    send_byte(8'h42, 1'b0, 0);
    check("ovf_clear", 64'(ovf_o), 64'd0);
    send_byte(8'h43, 1'b1, 0);
    finish_run();

    // Reset in the middle of a word: nothing written, no kick.
    send_byte(8'h5A, 1'b0, 0);
    send_byte(8'h5B, 1'b0, 0);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("mid_rst_ready", 64'(sif.s_ready_o), 64'd1);
    check("mid_rst_outs", {busy_o, start_run_o, ce_b0_o, we_b0_o}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wr_seen = 0;
    send_byte(8'hC1, 1'b0, 0);
    send_byte(8'hC2, 1'b0, 0);
    send_byte(8'hC3, 1'b0, 0);
    send_byte(8'hC4, 1'b1, 0);
    finish_run();
    check("post_rst_writes", 64'(wr_seen), 64'd1);

    repeat (3) @(posedge clk);
    check("wr_q_left", 64'(wr_q.size()), 64'd0);
    check("run_q_left", 64'(run_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
